mem_arbiter: RTL

- Shares one slave_mem-style memory slave between NUM_MASTERS bus masters using round-robin arbitration.
- Sequences each transfer: a one-cycle issue pulse to the slave, then a wait for the normal or split response, then a one-cycle response pulse back to the owning master.
- Drives the slave's split-start input for reads that the master flags as split.
- A watchdog converts a missing response into an error.
- Sits between the master-side bus ports and a single memory slave.

---
 rtl/bus_pkg.sv | 12 +
 rtl/rr_picker.sv | 30 +++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus widths and the arbiter state encoding for the memory-slave bus.
package bus_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requester after the last winner, wrapping at N.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // i runs 1..N so the previous winner is considered last
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory slave between NUM_MASTERS masters;
// each transfer runs IDLE -> ISSUE -> WAIT -> RESP with a watchdog on WAIT.
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_MASTERS-1:0]                 m_valid_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS-1:0]                 m_split_i,
  output logic [NUM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_MASTERS-1:0]                 m_ready_o,
  output logic [NUM_MASTERS-1:0]                 m_err_o,
  output logic [DATA_WIDTH-1:0]                  m_rdata_o,
  output logic                                   s_valid_o,
  output logic [ADDR_WIDTH-1:0]                  s_addr_o,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  output logic                                   s_we_o,
  output logic                                   s_split_start_o,
  input  logic                                   s_ready_i,
  input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
  input  logic                                   s_err_i,
  input  logic                                   s_split_ready_i
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       rr_last_q;
  logic [IDX_W-1:0]       owner_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic [CNT_W-1:0]       wait_cnt_nx;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic                   slave_done;

  rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req  (m_valid_i),
    .last (rr_last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // The first WAIT cycle counts as 1, so a silent slave is answered TIMEOUT cycles after gnt.
  assign wait_cnt_nx = wait_cnt_q + 1'b1;
  assign owner_oh    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
  assign slave_done  = s_ready_i | s_split_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      rr_last_q       <= IDX_W'(NUM_MASTERS - 1);
      owner_q         <= '0;
      wait_cnt_q      <= '0;
      m_gnt_o         <= '0;
      m_ready_o       <= '0;
      m_err_o         <= '0;
      m_rdata_o       <= '0;
      s_valid_o       <= 1'b0;
      s_addr_o        <= '0;
      s_wdata_o       <= '0;
      s_we_o          <= 1'b0;
      s_split_start_o <= 1'b0;
    end else begin
      s_valid_o       <= 1'b0;
      s_split_start_o <= 1'b0;
      m_gnt_o         <= '0;
      m_ready_o       <= '0;
      m_err_o         <= '0;
      case (state_q)
        IDLE: begin
          if (|m_valid_i) begin
            owner_q         <= pick_idx;
            rr_last_q       <= pick_idx;
            s_addr_o        <= m_addr_i[pick_idx];
            s_wdata_o       <= m_wdata_i[pick_idx];
            s_we_o          <= m_we_i[pick_idx];
            s_split_start_o <= m_split_i[pick_idx] & ~m_we_i[pick_idx];
            s_valid_o       <= 1'b1;
            m_gnt_o         <= pick_gnt;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (slave_done) begin
            m_rdata_o <= s_rdata_i;
            m_err_o   <= {NUM_MASTERS{s_err_i}} & owner_oh;
            m_ready_o <= owner_oh;
            state_q   <= RESP;
          end else if (wait_cnt_nx == CNT_W'(TIMEOUT - 1)) begin
            m_rdata_o <= '0;
            m_err_o   <= owner_oh;
            m_ready_o <= owner_oh;
            state_q   <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_nx;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
